nco_dac_spi_tx: RTL and testbench

//   Downstream of the 14-bit sin/cos NCO: captures each valid sin/cos pair, buffers it in a small FIFO and

---
 rtl/nco_dac_pkg.sv | 27 ++
 rtl/nco_dac_fifo.sv | 63 ++++++
 rtl/nco_dac_spi_tx.sv | 191 +++++++++++++++++++
 tb/tb_nco_dac_spi_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_dac_pkg.sv
// Shared definitions for the NCO-to-dual-DAC SPI transmitter.
//   FRAME_W  : SPI frame width for the default 14-bit sample (channel bits + code)
//   CH_A/CH_B: channel select prefixes carried in the top two bits of each frame
//   state_e  : transmitter FSM states
//   frame_w(): frame width for an arbitrary sample width
package nco_dac_pkg;

  localparam int unsigned DATA_W_DFLT = 14;
  localparam int unsigned FRAME_W     = DATA_W_DFLT + 2;

  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftA,
    StGap,
    StShiftB,
    StLdac
  } state_e;

  function automatic int unsigned frame_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/nco_dac_fifo.sv
// Synchronous FIFO buffering sin/cos pairs ahead of the SPI shifter.
// Read data is first-word fall-through (rdata_o shows the head entry while not empty).
// A push while full is still written if a pop happens in the same cycle.
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset (empties the FIFO)
//   push_i   in   write request
//   wdata_i  in   write data
//   pop_i    in   read request (ignored when empty)
//   rdata_o  out  head entry
//   full_o   out  FIFO holds Depth entries
//   empty_o  out  FIFO holds no entries
module nco_dac_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  // One extra pointer bit distinguishes full from empty.
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/nco_dac_spi_tx.sv
// Captures NCO sin/cos pairs into a FIFO and serialises each pair to a dual-channel SPI DAC:
// frame A (sin), a short CS-high gap, frame B (cos), then an LDAC low pulse loading both channels.
// Frame = {ch[1:0], code[DATA_W-1:0]}, MSB first; SDO changes on SCLK falling, SCLK idles low.
// Build option: define DAC_OFFSET_BIN_EN to send offset-binary codes (sample MSB inverted);
// otherwise the two's complement sample is sent unchanged.
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset; aborts any frame in progress
//   clken       in   qualifies in_valid
//   in_valid    in   NCO sample valid
//   sin_i       in   sine sample
//   cos_i       in   cosine sample
//   dac_sclk    out  SPI clock
//   dac_cs_n    out  SPI frame select, active low
//   dac_sdo     out  SPI serial data
//   dac_ldac_n  out  DAC load strobe, active low
//   busy        out  FSM active or FIFO not empty
//   overflow    out  sticky: a pair was dropped because the FIFO was full
module nco_dac_spi_tx
  import nco_dac_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sin_i,
  input  logic [DATA_W-1:0] cos_i,
  output logic              dac_sclk,
  output logic              dac_cs_n,
  output logic              dac_sdo,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned FrameW = frame_w(DATA_W);
  localparam int unsigned DivW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BitW   = $clog2(FrameW);

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [DATA_W-1:0] CodeFlip = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] CodeFlip = '0;
`endif

  // FIFO
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic [DATA_W-1:0]   head_sin, head_cos;

  // FSM and shift engine
  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              phase_q, phase_d;   // SCLK level while shifting; half-select in LDAC
  logic [BitW-1:0]   bit_q, bit_d;
  logic [FrameW-1:0] shreg_q, shreg_d;
  logic [FrameW-1:0] frame_b_q, frame_b_d;
  logic              div_last, bit_last, shifting_d;

  // Registered pins
  logic cs_n_q, sclk_q, sdo_q, ldac_n_q, overflow_q, overflow_d;

  assign fifo_push = clken & in_valid;
  assign fifo_pop  = (state_q == StLoad);

  nco_dac_fifo #(
    .Width (2 * DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({sin_i, cos_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_sin = fifo_rdata[2*DATA_W-1:DATA_W];
  assign head_cos = fifo_rdata[DATA_W-1:0];

  assign div_last = (div_q == DivW'(SCLK_DIV - 1));
  assign bit_last = (bit_q == BitW'(FrameW - 1));

  // Full is sampled before the same-cycle pop, so only a push with no pop is lost.
  assign overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    frame_b_d = frame_b_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        shreg_d   = {CH_A, head_sin ^ CodeFlip};
        frame_b_d = {CH_B, head_cos ^ CodeFlip};
        div_d     = '0;
        phase_d   = 1'b0;
        bit_d     = '0;
        state_d   = StShiftA;
      end
      StShiftA, StShiftB: begin
        if (div_last) begin
          div_d   = '0;
          phase_d = ~phase_q;
          // High-to-low SCLK transition: advance to the next bit.
          if (phase_q) begin
            shreg_d = shreg_q << 1;
            if (bit_last) begin
              bit_d   = '0;
              state_d = (state_q == StShiftA) ? StGap : StLdac;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_last) begin
          div_d   = '0;
          phase_d = 1'b0;
          shreg_d = frame_b_q;
          state_d = StShiftB;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLdac: begin
        // Two SCLK_DIV half-periods of LDAC low.
        if (div_last) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) state_d = fifo_empty ? StIdle : StLoad;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pins are registered from next-state so they switch on the same edge as the FSM.
  assign shifting_d = (state_d == StShiftA) || (state_d == StShiftB);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      shreg_q    <= '0;
      frame_b_q  <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      ldac_n_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      frame_b_q  <= frame_b_d;
      cs_n_q     <= ~shifting_d;
      sclk_q     <= shifting_d & phase_d;
      sdo_q      <= shifting_d & shreg_d[FrameW-1];
      ldac_n_q   <= ~(state_d == StLdac);
      overflow_q <= overflow_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sdo    = sdo_q;
  assign dac_ldac_n = ldac_n_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_nco_dac_spi_tx.sv
// Directed bench for nco_dac_spi_tx with default parameters and an SPI receiver model.
module tb_nco_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] sin_i = '0;
  logic [13:0] cos_i = '0;
  logic        dac_sclk, dac_cs_n, dac_sdo, dac_ldac_n, busy, overflow;

  always #5 clk = ~clk;

  nco_dac_spi_tx #(
    .DATA_W     (14),
    .FIFO_DEPTH (4),
    .SCLK_DIV   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .in_valid   (in_valid),
    .sin_i      (sin_i),
    .cos_i      (cos_i),
    .dac_sclk   (dac_sclk),
    .dac_cs_n   (dac_cs_n),
    .dac_sdo    (dac_sdo),
    .dac_ldac_n (dac_ldac_n),
    .busy       (busy),
    .overflow   (overflow)
  );

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [15:0] T1A = 16'h2000, T1B = 16'h7FFF, T2A = 16'h0000, T2B = 16'h5FFF;
`else
  localparam logic [15:0] T1A = 16'h0000, T1B = 16'h5FFF, T2A = 16'h2000, T2B = 16'h7FFF;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_frame(input logic [1:0] ch, input logic [13:0] s);
    logic [13:0] c;
    c = s;
`ifdef DAC_OFFSET_BIN_EN
    c[13] = ~c[13];
`endif
    return {ch, c};
  endfunction

  // SPI receiver model, sampled on the falling clk edge.
  logic [15:0] frames_q[$];
  int          rises_q[$];
  int          lowlen_q[$];
  int          gap_q[$];
  int          ldac_q[$];
  int          n_cs_fall, sdo_bad, cur_rises, cur_len, hi_len, ldac_len;
  logic [15:0] cur_frame;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0, ldac_prev = 1'b1;

  task automatic clear_mon();
    frames_q.delete(); rises_q.delete(); lowlen_q.delete(); gap_q.delete(); ldac_q.delete();
    n_cs_fall = 0;
    sdo_bad   = 0;
  endtask

  initial begin
    clear_mon();
    cur_rises = 0; cur_len = 0; hi_len = 0; ldac_len = 0; cur_frame = '0;
    forever begin
      @(negedge clk);
      if (!dac_cs_n) begin
        if (cs_prev) begin
          gap_q.push_back(hi_len);
          n_cs_fall++;
          cur_frame = '0;
          cur_rises = 0;
          cur_len   = 0;
        end
        cur_len++;
        if (dac_sclk && !sclk_prev) begin
          cur_frame = {cur_frame[14:0], dac_sdo};
          cur_rises++;
        end
      end else begin
        if (!cs_prev) begin
          frames_q.push_back(cur_frame);
          rises_q.push_back(cur_rises);
          lowlen_q.push_back(cur_len);
          if (dac_sdo !== 1'b0) sdo_bad++;
          hi_len = 0;
        end
        hi_len++;
      end
      if (!dac_ldac_n) begin
        if (ldac_prev) ldac_len = 0;
        ldac_len++;
      end else if (!ldac_prev) begin
        ldac_q.push_back(ldac_len);
      end
      cs_prev   = dac_cs_n;
      sclk_prev = dac_sclk;
      ldac_prev = dac_ldac_n;
    end
  end

  function automatic logic [15:0] frame_at(input int i);
    return (frames_q.size() > i) ? frames_q[i] : 16'hxxxx;
  endfunction
  function automatic int rise_at(input int i);
    return (rises_q.size() > i) ? rises_q[i] : -1;
  endfunction
  function automatic int low_at(input int i);
    return (lowlen_q.size() > i) ? lowlen_q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic push_pair(input logic [13:0] s, input logic [13:0] c);
    clken = 1'b1; in_valid = 1'b1; sin_i = s; cos_i = c;
    tick(1);
    clken = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_idle"}, busy, 1'b0);
    tick(2);
  endtask

  logic [13:0] s3 [6];
  logic [13:0] c3 [6];
  logic [13:0] s6 [100];
  logic [13:0] c6 [100];

  initial begin
    int lat, n, busy_cnt, bad;

    // Reset state
    do_reset();
    check_eq("rst_sclk", dac_sclk, 1'b0);
    check_eq("rst_cs_n", dac_cs_n, 1'b1);
    check_eq("rst_sdo", dac_sdo, 1'b0);
    check_eq("rst_ldac_n", dac_ldac_n, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);

    // 1: single pair, latency and frame timing
    clear_mon();
    clken = 1'b1; in_valid = 1'b1; sin_i = 14'h0000; cos_i = 14'h1FFF;
    tick(1);
    clken = 1'b0; in_valid = 1'b0;
    lat = 0;
    while (dac_cs_n && lat < 10) begin
      tick(1);
      lat++;
    end
    check_eq("t1_latency", lat, 2);
    wait_idle("t1", 400);
    check_eq("t1_nframes", frames_q.size(), 2);
    check_eq("t1_frame_a", frame_at(0), T1A);
    check_eq("t1_frame_b", frame_at(1), T1B);
    check_eq("t1_rises_a", rise_at(0), 16);
    check_eq("t1_rises_b", rise_at(1), 16);
    check_eq("t1_cslow_a", low_at(0), 64);
    check_eq("t1_cslow_b", low_at(1), 64);
    check_eq("t1_gap", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
    check_eq("t1_nldac", ldac_q.size(), 1);
    check_eq("t1_ldac_len", (ldac_q.size() > 0) ? ldac_q[0] : -1, 4);
    check_eq("t1_sdo_idle", sdo_bad, 0);

    // 2: negative full-scale and -1
    clear_mon();
    push_pair(14'h2000, 14'h3FFF);
    wait_idle("t2", 400);
    check_eq("t2_nframes", frames_q.size(), 2);
    check_eq("t2_frame_a", frame_at(0), T2A);
    check_eq("t2_frame_b", frame_at(1), T2B);
    check_eq("t2_sdo_idle", sdo_bad, 0);

    // 4: clken low blocks pushes
    clear_mon();
    clken = 1'b0; in_valid = 1'b1; sin_i = 14'h1234; cos_i = 14'h0ABC;
    busy_cnt = 0;
    repeat (10) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    in_valid = 1'b0;
    tick(5);
    check_eq("t4_busy_cycles", busy_cnt, 0);
    check_eq("t4_no_frames", n_cs_fall, 0);
    check_eq("t4_busy", busy, 1'b0);

    // 3: six back-to-back pairs, sixth dropped
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      s3[i] = 14'h0100 + 14'(i * 3);
      c3[i] = 14'h2A00 + 14'(i);
    end
    for (int i = 0; i < 6; i++) begin
      clken = 1'b1; in_valid = 1'b1; sin_i = s3[i]; cos_i = c3[i];
      tick(1);
    end
    clken = 1'b0; in_valid = 1'b0;
    check_eq("t3_overflow_set", overflow, 1'b1);
    wait_idle("t3", 1000);
    check_eq("t3_nframes", frames_q.size(), 10);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3_a%0d", i), frame_at(2 * i), exp_frame(2'b00, s3[i]));
      check_eq($sformatf("t3_b%0d", i), frame_at(2 * i + 1), exp_frame(2'b01, c3[i]));
    end
    tick(20);
    check_eq("t3_overflow_sticky", overflow, 1'b1);

    // 5: reset during frame A bit 7
    clear_mon();
    push_pair(14'h0F0F, 14'h30F0);
    n = 0;
    while (!(!dac_cs_n && cur_rises >= 7) && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("t5_reached_bit7", (!dac_cs_n && cur_rises >= 7), 1'b1);
    reset_n = 1'b0;
    tick(1);
    check_eq("t5_cs_n", dac_cs_n, 1'b1);
    check_eq("t5_sclk", dac_sclk, 1'b0);
    check_eq("t5_ldac_n", dac_ldac_n, 1'b1);
    check_eq("t5_sdo", dac_sdo, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    tick(300);
    check_eq("t5_no_b_frame", n_cs_fall, 1);
    check_eq("t5_no_ldac", ldac_q.size(), 0);

    // 6: sustained rate, one pair per 135 cycles
    do_reset();
    clear_mon();
    for (int i = 0; i < 100; i++) begin
      s6[i] = 14'(i * 1237 + 5);
      c6[i] = 14'(i * 421 + 9000);
    end
    for (int i = 0; i < 100; i++) begin
      push_pair(s6[i], c6[i]);
      tick(134);
    end
    wait_idle("t6", 1000);
    check_eq("t6_nframes", frames_q.size(), 200);
    for (int i = 0; i < 100; i++) begin
      check_eq($sformatf("t6_a%0d", i), frame_at(2 * i), exp_frame(2'b00, s6[i]));
      check_eq($sformatf("t6_b%0d", i), frame_at(2 * i + 1), exp_frame(2'b01, c6[i]));
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (rise_at(i) != 16 || low_at(i) != 64) bad++;
    end
    check_eq("t6_timing", bad, 0);
    check_eq("t6_nldac", ldac_q.size(), 100);
    check_eq("t6_overflow", overflow, 1'b0);
    check_eq("t6_sdo_idle", sdo_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
